// File: rtl/imm_gen_pkg.sv
// Shared opcode and format codes for the decode-stage immediate generator.
// Imported by the decoder and the pipeline top.
package imm_gen_pkg;

  localparam int FMT_WIDTH = 3;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [FMT_WIDTH-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_WIDTH-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_WIDTH-1:0] FMT_S   = 3'd2;
  localparam logic [FMT_WIDTH-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_WIDTH-1:0] FMT_U   = 3'd4;
  localparam logic [FMT_WIDTH-1:0] FMT_J   = 3'd5;
  localparam logic [FMT_WIDTH-1:0] FMT_ILL = 3'd7;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32 format classifier and immediate extractor.
// Builds a 32-bit signed immediate, then widens it to DATA_WIDTH.
import imm_gen_pkg::*;

module imm_decode #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter bit SUPPORT_UJ  = 1'b1
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [FMT_WIDTH-1:0]   fmt,
  output logic [DATA_WIDTH-1:0]  imm
);

  logic [6:0]  opc;
  logic [31:0] raw;
  logic is_r, is_i, is_s, is_b, is_u, is_j;

  assign opc  = instr[6:0];
  assign is_r = (opc == OP);
  assign is_i = (opc == LOAD) || (opc == OP_IMM)
             || (opc == JALR);
  assign is_s = (opc == STORE);
  assign is_b = (opc == BRANCH);
  assign is_u = SUPPORT_UJ
             && ((opc == LUI) || (opc == AUIPC));
  assign is_j = SUPPORT_UJ && (opc == JAL);

  always_comb begin
    fmt = FMT_ILL;
    raw = '0;
    unique case (1'b1)
      is_r: fmt = FMT_R;
      is_i: begin
        fmt = FMT_I;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      is_s: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25],
               instr[11:7]};
      end
      is_b: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7],
               instr[30:25], instr[11:8], 1'b0};
      end
      is_u: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'b0};
      end
      is_j: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31],
               instr[19:12], instr[20],
               instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a 2-entry skid buffer.
// Entry 0 drives out_*; entry 1 absorbs one word of back-pressure.
import imm_gen_pkg::*;

module imm_gen_pipe #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter bit SUPPORT_UJ  = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0]  out_imm,
  output logic [2:0]             out_fmt,
  output logic                   out_illegal,
  output logic [CNT_WIDTH-1:0]   illegal_cnt
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  imm;
    logic [FMT_WIDTH-1:0]   fmt;
  } entry_t;

  entry_t e0_q, e0_d, e1_q, e1_d, dec;
  logic   v0_q, v0_d, v1_q, v1_d;
  logic   rdy_q, rdy_d;
  logic   push, pop;
  logic [FMT_WIDTH-1:0]  dec_fmt;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  imm_decode #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .SUPPORT_UJ  (SUPPORT_UJ)
  ) u_dec (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign dec = '{instr: in_instr,
                 imm:   dec_imm,
                 fmt:   dec_fmt};

  assign push = in_valid && rdy_q;
  assign pop  = v0_q && out_ready;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    v0_d  = v0_q;
    v1_d  = v1_q;
    cnt_d = cnt_q;
    if (pop && (e0_q.fmt == FMT_ILL)
        && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
    // rdy_q is low whenever the skid slot is full
    if (v1_q) begin
      if (pop) begin
        e0_d = e1_q;
        v1_d = 1'b0;
      end
    end else if (pop && push) begin
      e0_d = dec;
    end else if (pop) begin
      v0_d = 1'b0;
    end else if (push) begin
      if (v0_q) begin
        e1_d = dec;
        v1_d = 1'b1;
      end else begin
        e0_d = dec;
        v0_d = 1'b1;
      end
    end
    if (flush) begin
      v0_d  = 1'b0;
      v1_d  = 1'b0;
      cnt_d = cnt_q;
    end
    rdy_d = !v1_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = v0_q;
  assign out_instr   = e0_q.instr;
  assign out_imm     = e0_q.imm;
  assign out_fmt     = e0_q.fmt;
  assign out_illegal = (e0_q.fmt == FMT_ILL);
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: random and directed words
// against an arithmetic reference decoder.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        in2_valid, in2_ready, out2_valid;
  logic [31:0] in2_instr, out2_instr;
  logic [63:0] out2_imm;
  logic [2:0]  out2_fmt;
  logic        out2_illegal;
  logic [1:0]  cnt2;

  exp_t        exp_q[$];
  exp_t        m_e;
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] cnt_snap;
  logic [6:0]  opc_tab [10];
  logic [31:0] w;

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .INSTR_WIDTH (32), .DATA_WIDTH (64),
    .SUPPORT_UJ  (1'b1), .CNT_WIDTH (16)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_instr (in_instr), .out_valid (out_valid),
    .out_ready (out_ready), .out_instr (out_instr),
    .out_imm (out_imm), .out_fmt (out_fmt),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  imm_gen_pipe #(
    .INSTR_WIDTH (32), .DATA_WIDTH (64),
    .SUPPORT_UJ  (1'b0), .CNT_WIDTH (2)
  ) u_dut2 (
    .clk (clk), .reset_n (reset_n), .flush (1'b0),
    .in_valid (in2_valid), .in_ready (in2_ready),
    .in_instr (in2_instr), .out_valid (out2_valid),
    .out_ready (1'b1), .out_instr (out2_instr),
    .out_imm (out2_imm), .out_fmt (out2_fmt),
    .out_illegal (out2_illegal),
    .illegal_cnt (cnt2)
  );

  // Reference: immediate value as signed integer arithmetic.
  function automatic exp_t model(input logic [31:0] x,
                                 input bit uj);
    exp_t   r;
    longint v;
    logic [2:0] f;
    v = 0;
    case (x[6:0])
      7'h03, 7'h13, 7'h67: begin
        f = 3'd1;
        v = longint'(x[31:20]);
        if (x[31]) v = v - 4096;
      end
      7'h23: begin
        f = 3'd2;
        v = longint'(x[31:25]) * 32
          + longint'(x[11:7]);
        if (x[31]) v = v - 4096;
      end
      7'h63: begin
        f = 3'd3;
        v = longint'(x[7]) * 2048
          + longint'(x[30:25]) * 32
          + longint'(x[11:8]) * 2;
        if (x[31]) v = v - 4096;
      end
      7'h37, 7'h17: begin
        f = 3'd4;
        v = longint'(x[31:12]) * 4096;
        if (x[31]) v = v - (longint'(1) << 32);
      end
      7'h6F: begin
        f = 3'd5;
        v = longint'(x[19:12]) * 4096
          + longint'(x[20]) * 2048
          + longint'(x[30:21]) * 2;
        if (x[31]) v = v - (longint'(1) << 20);
      end
      7'h33: f = 3'd0;
      default: f = 3'd7;
    endcase
    if (!uj && (f == 3'd4 || f == 3'd5)) begin
      f = 3'd7;
      v = 0;
    end
    r.instr = x;
    r.imm   = 64'(v);
    r.fmt   = f;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = x;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no in_ready want 1");
    end
    @(posedge clk);
    #1;
  endtask

  // Record accepted words.
  always @(negedge clk) begin
    if (reset_n && !flush && in_valid && in_ready)
      exp_q.push_back(model(in_instr, 1'b1));
  end

  // Compare delivered words and the counter.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
      if (!reset_n || flush) begin
        exp_q.delete();
        if (!reset_n) exp_cnt = '0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h want none",
                   out_instr);
        end else begin
          m_e = exp_q.pop_front();
          chk("out_instr", 64'(out_instr), 64'(m_e.instr));
          chk("out_imm", out_imm, m_e.imm);
          chk("out_fmt", 64'(out_fmt), 64'(m_e.fmt));
          chk("out_illegal", 64'(out_illegal),
              64'(m_e.fmt == 3'd7));
          if (m_e.fmt == 3'd7 && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    opc_tab = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    in2_valid = 1'b0;
    in2_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_fmt", 64'(out_fmt), 64'd0);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    send(32'hFFC12083);
    in_valid = 1'b0;
    chk("lw_valid", 64'(out_valid), 64'd1);
    chk("lw_fmt", 64'(out_fmt), 64'd1);
    chk("lw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h00512423);
    in_valid = 1'b0;
    chk("sw_fmt", 64'(out_fmt), 64'd2);
    chk("sw_imm", out_imm, 64'h8);
    send(32'hFE208CE3);
    in_valid = 1'b0;
    chk("beq_fmt", 64'(out_fmt), 64'd3);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    send(32'h800000B7);
    in_valid = 1'b0;
    chk("lui_fmt", 64'(out_fmt), 64'd4);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    send(32'h0080006F);
    in_valid = 1'b0;
    chk("jal_fmt", 64'(out_fmt), 64'd5);
    chk("jal_imm", out_imm, 64'h8);
    send(32'h002081B3);
    in_valid = 1'b0;
    chk("add_fmt", 64'(out_fmt), 64'd0);
    chk("add_imm", out_imm, 64'h0);

    repeat (3) send(32'h0000007F);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ill_cnt3", 64'(illegal_cnt), 64'd3);

    in2_instr = 32'h800000B7;
    in2_valid = 1'b1;
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
    chk("nouj_valid", 64'(out2_valid), 64'd1);
    chk("nouj_fmt", 64'(out2_fmt), 64'd7);
    chk("nouj_imm", out2_imm, 64'd0);
    chk("nouj_ill", 64'(out2_illegal), 64'd1);
    in2_instr = 32'h0000007F;
    in2_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in2_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_sat", 64'(cnt2), 64'd3);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00A00093;
    @(negedge clk);
    chk("bp_rdyA", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_instr = 32'h00512423;
    @(negedge clk);
    chk("bp_rdyB", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_instr = 32'h800000B7;
    repeat (2) begin
      @(negedge clk);
      chk("bp_full", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(out_instr), 64'h00A00093);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_outA", 64'(out_instr), 64'h00A00093);
    @(negedge clk);
    chk("bp_outB", 64'(out_instr), 64'h00512423);
    chk("bp_rdy2", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_outC_v", 64'(out_valid), 64'd1);
    chk("bp_outC", 64'(out_instr), 64'h800000B7);
    @(posedge clk);
    #1;

    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0)
        w[6:0] = opc_tab[$urandom_range(0, 9)];
      in_instr = w;
      @(negedge clk);
      chk("stream_rdy", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(32'h1234507F);
    send(32'h5678907F);
    in_instr = 32'h9ABC007F;
    flush    = 1'b1;
    cnt_snap = exp_cnt;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("fl_cnt", 64'(illegal_cnt), 64'(cnt_snap));

    out_ready = 1'b0;
    send(32'h00A00093);
    send(32'h0000007F);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd0);
    chk("mr_instr", 64'(out_instr), 64'd0);
    chk("mr_imm", out_imm, 64'd0);
    chk("mr_fmt", 64'(out_fmt), 64'd0);
    chk("mr_ill", 64'(out_illegal), 64'd0);
    chk("mr_cnt", 64'(illegal_cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_ready1", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'hFFC12083);
    in_valid = 1'b0;
    chk("mr_lat_v", 64'(out_valid), 64'd1);
    chk("mr_lat", 64'(out_instr), 64'hFFC12083);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
